guess_input_frontend: RTL and testbench

//  Input-side counterpart of the display path. Conditions the raw switch bank and

---
 rtl/guess_input_frontend.sv | 130 +++++++++++++
 tb/tb_guess_input_frontend.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_input_frontend.sv
// Bulls & Cows guess input path: synchronise switches and confirm, debounce
// confirm, snapshot the switches on each press and grade the four BCD digits.
module guess_input_frontend #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  input  logic        confirm,
  output logic [15:0] guess,
  output logic        guess_strobe,
  output logic        guess_ok,
  output logic [1:0]  err_code,
  output logic        btn_level
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [15:0]            sw_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] cf_pipe;
  logic [15:0]            sync_sw;
  logic                   sync_confirm;
  logic [CW-1:0]          cnt;
  logic                   btn_prev;
  logic                   btn_rise;
  logic [1:0]             state;
  logic [15:0]            snap;
  logic                   bad_digit;
  logic                   dup;
  logic [1:0]             err_next;

  assign sync_sw      = sw_pipe[SYNC_STAGES-1];
  assign sync_confirm = cf_pipe[SYNC_STAGES-1];
  assign btn_rise     = btn_level & ~btn_prev;

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cf_pipe <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sw_pipe[i] <= '0;
    end else begin
      cf_pipe    <= {cf_pipe[SYNC_STAGES-2:0], confirm};
      sw_pipe[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++)
        sw_pipe[i] <= sw_pipe[i-1];
    end
  end

  // Level flips only after an unbroken run of mismatching cycles.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      btn_prev <= btn_level;
      if (sync_confirm == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        btn_level <= ~btn_level;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    dup       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (snap[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
      for (int j = i + 1; j < 4; j++)
        if (snap[4*i +: 4] == snap[4*j +: 4])
          dup = 1'b1;
    end
  end

  // A bad digit outranks a repeat.
  always_comb begin
    err_next = 2'b00;
    priority case (1'b1)
      bad_digit: err_next = 2'b01;
      dup:       err_next = 2'b10;
      default:   err_next = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      snap         <= '0;
      guess        <= '0;
      guess_strobe <= 1'b0;
      guess_ok     <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      guess_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_rise) begin
            state <= CHECK;
            snap  <= sync_sw;
          end
        end
        CHECK: begin
          state        <= HOLD;
          guess        <= snap;
          guess_ok     <= (err_next == 2'b00);
          err_code     <= err_next;
          guess_strobe <= 1'b1;
        end
        HOLD: begin
          if (!btn_level)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_input_frontend.sv
// Randomised bench for guess_input_frontend against a behavioural model,
// plus directed presses with hand-computed expectations.
module tb_guess_input_frontend;

  localparam int NS = 2;
  localparam int ND = 4;

  logic        clock = 1'b0;
  logic        CPU_RESETN = 1'b1;
  logic [15:0] SW = '0;
  logic        confirm = 1'b0;
  logic [15:0] guess;
  logic        guess_strobe;
  logic        guess_ok;
  logic [1:0]  err_code;
  logic        btn_level;

  guess_input_frontend #(
    .SYNC_STAGES(NS),
    .DEBOUNCE_CYCLES(ND)
  ) dut (
    .clock(clock),
    .CPU_RESETN(CPU_RESETN),
    .SW(SW),
    .confirm(confirm),
    .guess(guess),
    .guess_strobe(guess_strobe),
    .guess_ok(guess_ok),
    .err_code(err_code),
    .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] grade(input logic [15:0] g);
    logic bad;
    logic rep;
    bad = 1'b0;
    rep = 1'b0;
    for (int a = 0; a < 4; a++) begin
      if (g[4*a +: 4] > 4'd9) bad = 1'b1;
      for (int b = a + 1; b < 4; b++)
        if (g[4*a +: 4] == g[4*b +: 4]) rep = 1'b1;
    end
    if (bad) return 2'b01;
    if (rep) return 2'b10;
    return 2'b00;
  endfunction

  // Behavioural model: delayed inputs, run-length debounce, event scheduled
  // two cycles after the debounced rise with the snapshot taken in between.
  logic [15:0] m_sw_d [NS];
  logic        m_cf_d [NS];
  int          m_run = 0;
  int          m_stage = 0;
  logic        m_btn = 1'b0;
  logic [15:0] m_pend = '0;
  logic        m_strobe = 1'b0;
  logic [15:0] m_guess = '0;
  logic        m_ok = 1'b0;
  logic [1:0]  m_err = 2'b00;

  always @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < NS; i++) begin
        m_sw_d[i] = '0;
        m_cf_d[i] = 1'b0;
      end
      m_run    = 0;
      m_stage  = 0;
      m_btn    = 1'b0;
      m_pend   = '0;
      m_strobe = 1'b0;
      m_guess  = '0;
      m_ok     = 1'b0;
      m_err    = 2'b00;
    end else begin
      m_strobe = 1'b0;
      if (m_stage == 2) begin
        m_strobe = 1'b1;
        m_guess  = m_pend;
        m_err    = grade(m_pend);
        m_ok     = (m_err == 2'b00);
        m_stage  = 0;
      end else if (m_stage == 1) begin
        m_pend  = m_sw_d[NS-1];
        m_stage = 2;
      end
      if (m_cf_d[NS-1] == m_btn) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == ND) begin
          m_btn = ~m_btn;
          m_run = 0;
          if (m_btn) m_stage = 1;
        end
      end
      for (int i = NS - 1; i > 0; i--) begin
        m_sw_d[i] = m_sw_d[i-1];
        m_cf_d[i] = m_cf_d[i-1];
      end
      m_sw_d[0] = SW;
      m_cf_d[0] = confirm;
    end
  end

  int          strobes = 0;
  logic [15:0] last_g = '0;

  always @(negedge clock) begin
    chk("strobe", guess_strobe, m_strobe);
    chk("guess", guess, m_guess);
    chk("ok", guess_ok, m_ok);
    chk("err", err_code, m_err);
    chk("btn", btn_level, m_btn);
    if (guess_strobe === 1'b1) begin
      strobes++;
      last_g = guess;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_guess"}, guess, 16'h0);
    chk({tag, "_strobe"}, guess_strobe, 1'b0);
    chk({tag, "_ok"}, guess_ok, 1'b0);
    chk({tag, "_err"}, err_code, 2'b00);
    chk({tag, "_btn"}, btn_level, 1'b0);
  endtask

  task automatic release_btn();
    confirm = 1'b0;
    step(12);
  endtask

  task automatic press(input logic [15:0] s, input logic [1:0] eerr,
                       input logic eok);
    int lat;
    int n;
    lat = -1;
    n = 0;
    SW = s;
    confirm = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (guess_strobe === 1'b1) begin
        n++;
        if (lat < 0) lat = i;
        chk("lit_guess", guess, s);
        chk("lit_err", err_code, eerr);
        chk("lit_ok", guess_ok, eok);
      end
    end
    chk("lit_latency", lat - 1, 8);
    chk("lit_count", n, 1);
    @(posedge clock);
    #2;
    release_btn();
  endtask

  initial begin
    int s0;
    logic [15:0] s;
    #1 CPU_RESETN = 1'b0;
    #1 chk_zero("rst0");
    step(5);
    chk_zero("rst5");
    CPU_RESETN = 1'b1;
    step(3);

    press(16'h1234, 2'b00, 1'b1);

    s0 = strobes;
    SW = 16'h0987;
    for (int i = 0; i < 8; i++) begin
      confirm = ~confirm;
      step(2);
    end
    chk("bounce_none", strobes - s0, 0);
    confirm = 1'b1;
    step(12);
    chk("bounce_one", strobes - s0, 1);
    chk("bounce_guess", last_g, 16'h0987);
    for (int i = 0; i < 8; i++) begin
      confirm = ~confirm;
      step(2);
    end
    release_btn();
    chk("bounce_release", strobes - s0, 1);

    press(16'h12A4, 2'b01, 1'b0);
    press(16'h1231, 2'b10, 1'b0);
    press(16'hAA11, 2'b01, 1'b0);
    press(16'h9876, 2'b00, 1'b1);

    s0 = strobes;
    SW = 16'h5173;
    confirm = 1'b1;
    step(20);
    SW = 16'h0000;
    step(180);
    chk("hold_one", strobes - s0, 1);
    chk("hold_guess", last_g, 16'h5173);
    release_btn();
    press(16'h2468, 2'b00, 1'b1);

    SW = 16'h3579;
    confirm = 1'b1;
    step(20);
    SW = 16'h8012;
    @(posedge clock);
    #3 CPU_RESETN = 1'b0;
    #1 chk_zero("rst_hold");
    step(3);
    s0 = strobes;
    CPU_RESETN = 1'b1;
    step(20);
    chk("rst_one", strobes - s0, 1);
    chk("rst_guess", last_g, 16'h8012);
    release_btn();

    for (int it = 0; it < 60; it++) begin
      s = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 4; k++)
          s[4*k +: 4] = 4'($urandom_range(0, 9));
      SW = s;
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        confirm = ~confirm;
        step($urandom_range(1, 3));
      end
      confirm = 1'b1;
      step($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) SW = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #3 CPU_RESETN = 1'b0;
        step(2);
        CPU_RESETN = 1'b1;
      end
      step($urandom_range(0, 12));
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        confirm = ~confirm;
        step($urandom_range(1, 3));
      end
      confirm = 1'b0;
      step($urandom_range(0, 14));
    end
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
